// File: rtl/core_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data bus arbiter.
// Optional perf counters are built when CORE_BUS_ARB_PERF_EN is defined.
package core_bus_arbiter_pkg;

   localparam int ARB_ADDR_W       = 64;
   localparam int ARB_DATA_W       = 64;
   localparam int ARB_STARVE_LIMIT = 4;

   localparam logic [2:0] MSIZE_WORD = 3'b010;

   typedef enum logic [1:0] {
      IDLE,
      GNT_I,
      GNT_D
   } arb_state_t;

   typedef struct packed {
      logic [ARB_ADDR_W-1:0]   addr;
      logic [2:0]              size;
      logic [ARB_DATA_W/8-1:0] strobe;
      logic [ARB_DATA_W-1:0]   wdata;
   } arb_req_t;

endpackage

// File: rtl/core_bus_arb_starve.sv
// Saturating count of data grants taken while a fetch waits;
// raises force_i once the fetch side has waited long enough.
module core_bus_arb_starve #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_valid,
   input  logic idle,
   input  logic grant_i,
   input  logic grant_d,
   output logic force_i
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

   logic [CW-1:0] cnt;

   assign force_i = (cnt == LIM);

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (grant_i) begin
         cnt <= '0;
      end else if (grant_d && i_valid) begin
         if (cnt != LIM)
            cnt <= cnt + 1'b1;
      end else if (idle && !i_valid) begin
         cnt <= '0;
      end
   end

endmodule

// File: rtl/core_bus_arbiter.sv
// Shares one single-beat memory port between fetch and data buses.
// Define CORE_BUS_ARB_PERF_EN to add the perf_* counter outputs.
module core_bus_arbiter
   import core_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W       = ARB_ADDR_W,
   parameter int DATA_W       = ARB_DATA_W,
   parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_valid,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_data_ok,
   output logic [31:0]         i_data,
   input  logic                d_valid,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [2:0]          d_size,
   input  logic [DATA_W/8-1:0] d_strobe,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_data_ok,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                m_valid,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [2:0]          m_size,
   output logic [DATA_W/8-1:0] m_strobe,
   output logic [DATA_W-1:0]   m_wdata,
   input  logic                m_data_ok,
   input  logic [DATA_W-1:0]   m_rdata
`ifdef CORE_BUS_ARB_PERF_EN
   ,
   output logic [31:0]         perf_i_grants,
   output logic [31:0]         perf_d_grants,
   output logic [31:0]         perf_i_wait,
   output logic [31:0]         perf_starve_forced
`endif
);

   localparam int SW = DATA_W / 8;

   arb_state_t state, state_nx;
   arb_req_t   req_q, req_nx;
   logic       m_valid_q;
   logic       idle, force_i;
   logic       grant_i, grant_d;

   core_bus_arb_starve #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_starve (
      .clk    (clk),
      .reset  (reset),
      .i_valid(i_valid),
      .idle   (idle),
      .grant_i(grant_i),
      .grant_d(grant_d),
      .force_i(force_i)
   );

   always_comb begin
      idle     = (state == IDLE);
      grant_d  = idle && d_valid && !(i_valid && force_i);
      grant_i  = idle && i_valid && !grant_d;
      state_nx = state;
      req_nx   = req_q;
      unique case (1'b1)
         grant_d: begin
            state_nx      = GNT_D;
            req_nx.addr   = ARB_ADDR_W'(d_addr);
            req_nx.size   = d_size;
            req_nx.strobe = (ARB_DATA_W/8)'(d_strobe);
            req_nx.wdata  = ARB_DATA_W'(d_wdata);
         end
         grant_i: begin
            state_nx      = GNT_I;
            req_nx.addr   = ARB_ADDR_W'(i_addr);
            req_nx.size   = MSIZE_WORD;
            req_nx.strobe = '0;
            req_nx.wdata  = '0;
         end
         (!idle && m_data_ok): begin
            state_nx = IDLE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         req_q     <= '0;
         m_valid_q <= 1'b0;
      end else begin
         state     <= state_nx;
         req_q     <= req_nx;
         m_valid_q <= (state_nx != IDLE);
      end
   end

   assign m_valid  = m_valid_q;
   assign m_addr   = req_q.addr[ADDR_W-1:0];
   assign m_size   = req_q.size;
   assign m_strobe = req_q.strobe[SW-1:0];
   assign m_wdata  = req_q.wdata[DATA_W-1:0];

   // Response is steered purely by the granted state, no extra stage.
   always_comb begin
      i_data_ok = (state == GNT_I) && m_data_ok;
      d_data_ok = (state == GNT_D) && m_data_ok;
      i_data    = '0;
      d_rdata   = '0;
      if (state == GNT_I)
         i_data = req_q.addr[2] ? m_rdata[63:32] : m_rdata[31:0];
      if (state == GNT_D)
         d_rdata = m_rdata;
   end

`ifdef CORE_BUS_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_i_grants      <= '0;
         perf_d_grants      <= '0;
         perf_i_wait        <= '0;
         perf_starve_forced <= '0;
      end else begin
         if (grant_i)
            perf_i_grants <= perf_i_grants + 1;
         if (grant_d)
            perf_d_grants <= perf_d_grants + 1;
         if (i_valid && state != GNT_I && !grant_i)
            perf_i_wait <= perf_i_wait + 1;
         // I winning while D is also asking only happens via force_i.
         if (grant_i && d_valid)
            perf_starve_forced <= perf_starve_forced + 1;
      end
   end
`endif

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Scoreboard bench for core_bus_arbiter: directed vectors,
// grant/response expectations queued and checked by a monitor.
module tb_core_bus_arbiter;

   logic        clk;
   logic        reset;
   logic        i_valid;
   logic [63:0] i_addr;
   logic        i_data_ok;
   logic [31:0] i_data;
   logic        d_valid;
   logic [63:0] d_addr;
   logic [2:0]  d_size;
   logic [7:0]  d_strobe;
   logic [63:0] d_wdata;
   logic        d_data_ok;
   logic [63:0] d_rdata;
   logic        m_valid;
   logic [63:0] m_addr;
   logic [2:0]  m_size;
   logic [7:0]  m_strobe;
   logic [63:0] m_wdata;
   logic        m_data_ok;
   logic [63:0] m_rdata;
`ifdef CORE_BUS_ARB_PERF_EN
   logic [31:0] perf_i_grants;
   logic [31:0] perf_d_grants;
   logic [31:0] perf_i_wait;
   logic [31:0] perf_starve_forced;
`endif

   core_bus_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .i_valid  (i_valid),
      .i_addr   (i_addr),
      .i_data_ok(i_data_ok),
      .i_data   (i_data),
      .d_valid  (d_valid),
      .d_addr   (d_addr),
      .d_size   (d_size),
      .d_strobe (d_strobe),
      .d_wdata  (d_wdata),
      .d_data_ok(d_data_ok),
      .d_rdata  (d_rdata),
      .m_valid  (m_valid),
      .m_addr   (m_addr),
      .m_size   (m_size),
      .m_strobe (m_strobe),
      .m_wdata  (m_wdata),
      .m_data_ok(m_data_ok),
      .m_rdata  (m_rdata)
`ifdef CORE_BUS_ARB_PERF_EN
      ,
      .perf_i_grants     (perf_i_grants),
      .perf_d_grants     (perf_d_grants),
      .perf_i_wait       (perf_i_wait),
      .perf_starve_forced(perf_starve_forced)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] addr;
      logic [7:0]  strobe;
      logic [2:0]  size;
   } gnt_t;

   typedef struct {
      bit          is_d;
      logic [63:0] data;
   } resp_t;

   gnt_t  gq[$];
   resp_t rq[$];
   int    checks = 0;
   int    errors = 0;
   logic  mv_prev = 1'b0;

   function automatic void chk(string name, logic [63:0] act,
                               logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic void push_g(logic [63:0] a, logic [7:0] s,
                                  logic [2:0] z);
      gnt_t g;
      g.addr = a;
      g.strobe = s;
      g.size = z;
      gq.push_back(g);
   endfunction

   function automatic void push_r(bit is_d, logic [63:0] dat);
      resp_t r;
      r.is_d = is_d;
      r.data = dat;
      rq.push_back(r);
   endfunction

   always @(negedge clk) begin
      gnt_t  g;
      resp_t r;
      if (m_valid && !mv_prev) begin
         if (gq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL grant_unexpected: got %h expected none",
                     m_addr);
         end else begin
            g = gq.pop_front();
            chk("grant_addr", m_addr, g.addr);
            chk("grant_strobe", 64'(m_strobe), 64'(g.strobe));
            chk("grant_size", 64'(m_size), 64'(g.size));
         end
      end
      mv_prev = m_valid;
      if (i_data_ok || d_data_ok) begin
         chk("resp_onehot", 64'(i_data_ok & d_data_ok), 64'd0);
         if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_unexpected: got i=%b d=%b expected none",
                     i_data_ok, d_data_ok);
         end else begin
            r = rq.pop_front();
            chk("resp_port", 64'(d_data_ok), 64'(r.is_d));
            chk("resp_data",
                d_data_ok ? d_rdata : {32'h0, i_data}, r.data);
         end
      end
   end

   task automatic wait_grant(output int n);
      n = 0;
      while (!m_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!m_valid) begin
         checks++;
         errors++;
         $display("FAIL grant_timeout: got none expected m_valid");
      end
   endtask

   task automatic respond(input int lat, input logic [63:0] rd);
      repeat (lat - 1) begin
         @(posedge clk);
         #1;
      end
      m_rdata = rd;
      m_data_ok = 1'b1;
      @(posedge clk);
      #1;
      m_data_ok = 1'b0;
   endtask

   logic [63:0] st_rd [6] = '{
      64'hA0A0_0000_B0B0_0000, 64'hA0A0_0001_B0B0_0001,
      64'hA0A0_0002_B0B0_0002, 64'hA0A0_0003_B0B0_0003,
      64'hA0A0_0004_B0B0_0004, 64'hA0A0_0005_B0B0_0005
   };
   logic [63:0] st_exp [6] = '{
      64'hA0A0_0000_B0B0_0000, 64'hA0A0_0001_B0B0_0001,
      64'hA0A0_0002_B0B0_0002, 64'hA0A0_0003_B0B0_0003,
      64'h0000_0000_B0B0_0004, 64'hA0A0_0005_B0B0_0005
   };
   logic [63:0] st_gad [6] = '{
      64'h8000_1100, 64'h8000_1108, 64'h8000_1110,
      64'h8000_1118, 64'h8000_0100, 64'h8000_1120
   };

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      reset = 1'b0;
      i_valid = 1'b1;
      i_addr = 64'h8000_0000;
      d_valid = 1'b0;
      d_addr = '0;
      d_size = 3'd0;
      d_strobe = 8'h00;
      d_wdata = '0;
      m_data_ok = 1'b0;
      m_rdata = '0;

      // reset held with a pending fetch
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_addr", m_addr, 64'd0);
      chk("rst_data_ok", 64'({i_data_ok, d_data_ok}), 64'd0);
      push_g(64'h8000_0000, 8'h00, 3'b010);
      push_r(1'b0, 64'h0000_0013);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("first_grant_lat", 64'(m_valid), 64'd1);
      respond(1, 64'h1111_2222_0000_0013);
      i_valid = 1'b0;

      // simultaneous requests, then upper-word fetch
      push_g(64'h8000_1008, 8'hFF, 3'b011);
      push_r(1'b1, 64'h0102_0304_0506_0708);
      push_g(64'h8000_0004, 8'h00, 3'b010);
      push_r(1'b0, 64'hDEAD_BEEF);
      i_valid = 1'b1;
      i_addr = 64'h8000_0004;
      d_valid = 1'b1;
      d_addr = 64'h8000_1008;
      d_size = 3'b011;
      d_strobe = 8'hFF;
      d_wdata = 64'hCAFE_F00D_1234_5678;
      wait_grant(n);
      chk("sim_grant_lat", 64'(n), 64'd1);
      chk("sim_m_wdata", m_wdata, 64'hCAFE_F00D_1234_5678);
      respond(2, 64'h0102_0304_0506_0708);
      d_valid = 1'b0;
      chk("gap_idle", 64'(m_valid), 64'd0);
      wait_grant(n);
      chk("gap_cycles", 64'(n), 64'd1);
      respond(1, 64'hDEAD_BEEF_0000_0000);
      i_valid = 1'b0;

      // starvation: D,D,D,D,I,D
      for (int k = 0; k < 6; k++) begin
         push_g(st_gad[k], 8'h00, (k == 4) ? 3'b010 : 3'b011);
         push_r(k != 4, st_exp[k]);
      end
      i_valid = 1'b1;
      i_addr = 64'h8000_0100;
      d_valid = 1'b1;
      d_addr = 64'h8000_1100;
      d_size = 3'b011;
      d_strobe = 8'h00;
      for (int k = 0; k < 6; k++) begin
         wait_grant(n);
         respond(1 + (k % 2), st_rd[k]);
         if (k < 4)
            d_addr = d_addr + 64'd8;
         if (k == 4)
            i_valid = 1'b0;
      end
      d_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
`ifdef CORE_BUS_ARB_PERF_EN
      chk("perf_starve", 64'(perf_starve_forced), 64'd1);
`endif

      // requester drops valid mid-transaction
      push_g(64'h8000_2000, 8'h0F, 3'b010);
      push_r(1'b1, 64'h5555_6666_7777_8888);
      d_valid = 1'b1;
      d_addr = 64'h8000_2000;
      d_size = 3'b010;
      d_strobe = 8'h0F;
      d_wdata = 64'h1234;
      wait_grant(n);
      d_valid = 1'b0;
      d_addr = 64'hFFFF_FFFF_FFFF_FFF8;
      d_strobe = 8'h00;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("drop_m_valid", 64'(m_valid), 64'd1);
      chk("drop_m_addr", m_addr, 64'h8000_2000);
      chk("drop_m_strobe", 64'(m_strobe), 64'h0F);
      respond(3, 64'h5555_6666_7777_8888);
      chk("drop_done_valid", 64'(m_valid), 64'd0);
      chk("drop_ok_once", 64'(d_data_ok), 64'd0);
      @(posedge clk);
      #1;
      chk("drop_no_regrant", 64'(m_valid), 64'd0);

      // reset during a data transaction, then a stray completion
      push_g(64'h8000_3000, 8'h03, 3'b001);
      d_valid = 1'b1;
      d_addr = 64'h8000_3000;
      d_size = 3'b001;
      d_strobe = 8'h03;
      wait_grant(n);
      d_valid = 1'b0;
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      chk("mid_rst_valid", 64'(m_valid), 64'd0);
      chk("mid_rst_addr", m_addr, 64'd0);
      m_rdata = 64'h9999_9999_9999_9999;
      m_data_ok = 1'b1;
      @(negedge clk);
      chk("stray_ok", 64'({i_data_ok, d_data_ok}), 64'd0);
      @(posedge clk);
      #1;
      m_data_ok = 1'b0;
      chk("stray_no_grant", 64'(m_valid), 64'd0);

      repeat (2) @(posedge clk);
      #1;
      chk("grants_left", 64'(gq.size()), 64'd0);
      chk("resps_left", 64'(rq.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
